// File: rtl/hb3_array.sv
// Multi-channel H-bridge PWM driver with a shared period counter.
// Direction reversals pass through a forced-off dead time per channel.
module hb3_array #(
    parameter int CHANNELS  = 2,
    parameter int WIDTH     = 8,
    parameter int PRESCALE  = 1,
    parameter int DEAD_TIME = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] speed,
    input  logic [CHANNELS-1:0]       direction_control,
    output logic [CHANNELS-1:0]       motor_enable,
    output logic [CHANNELS-1:0]       motor_direction,
    output logic [CHANNELS-1:0]       busy,
    output logic                      period_start
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int DW = (DEAD_TIME > 1) ? $clog2(DEAD_TIME) : 1;
    localparam logic [PW-1:0] PRE_LAST  = PW'(PRESCALE - 1);
    localparam logic [DW-1:0] DEAD_LOAD = DW'(DEAD_TIME - 1);

    typedef enum logic {
        ST_RUN,
        ST_DEAD
    } state_t;

    logic [PW-1:0]    r_pre;
    logic [WIDTH-1:0] r_cnt;
    logic             r_period_start;
    logic             w_tick;
    logic             w_wrap;

    // With PRESCALE=1 the prescaler never leaves 0, so tick stays high.
    assign w_tick = (r_pre == PRE_LAST);
    assign w_wrap = w_tick && (r_cnt == '1);

    assign period_start = r_period_start;

    // Prescaler: counts clk cycles between PWM counter ticks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pre <= '0;
        end else begin
            r_pre <= w_tick ? '0 : r_pre + PW'(1);
        end
    end

    // Shared free-running PWM counter and period boundary pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt          <= '0;
            r_period_start <= 1'b0;
        end else begin
            if (w_tick) begin
                r_cnt <= r_cnt + WIDTH'(1);
            end
            r_period_start <= w_wrap;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [WIDTH-1:0] r_shadow;
        state_t           r_state;
        state_t           w_state_nx;
        logic [DW-1:0]    r_dead;
        logic [DW-1:0]    w_dead_nx;
        logic             r_en;
        logic             w_en_nx;
        logic             r_dir;
        logic             w_dir_nx;
        logic             w_raw;

        // Shadow duty only changes at a period boundary.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_shadow <= '0;
            end else if (w_wrap) begin
                r_shadow <= speed[g*WIDTH +: WIDTH];
            end
        end

        assign w_raw = (r_shadow == '1) || (r_cnt < r_shadow);

        // Next-state: RUN follows PWM, DEAD holds the bridge off.
        always_comb begin
            w_state_nx = r_state;
            w_dead_nx  = r_dead;
            w_en_nx    = 1'b0;
            w_dir_nx   = r_dir;
            unique case (r_state)
                ST_RUN: begin
                    if (direction_control[g] != r_dir) begin
                        w_state_nx = ST_DEAD;
                        w_dead_nx  = DEAD_LOAD;
                    end else begin
                        w_en_nx = w_raw;
                    end
                end
                ST_DEAD: begin
                    if (r_dead == '0) begin
                        w_state_nx = ST_RUN;
                        w_dir_nx   = direction_control[g];
                    end else begin
                        w_dead_nx = r_dead - DW'(1);
                    end
                end
            endcase
        end

        // Channel state and registered bridge outputs.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_state <= ST_RUN;
                r_dead  <= '0;
                r_en    <= 1'b0;
                r_dir   <= 1'b0;
            end else begin
                r_state <= w_state_nx;
                r_dead  <= w_dead_nx;
                r_en    <= w_en_nx;
                r_dir   <= w_dir_nx;
            end
        end

        assign motor_enable[g]    = r_en;
        assign motor_direction[g] = r_dir;
        assign busy[g]            = (r_state == ST_DEAD);
    end

endmodule

// File: doc/hb3_array.md
HB3_ARRAY -- requirements
Module: hb3_array

Interface
REQ-001 SHALL have parameter CHANNELS, default 2: number of independent H-bridge channels (>=1).
REQ-002 SHALL have parameter WIDTH, default 8: PWM resolution in bits (>=2).
REQ-003 SHALL have parameter PRESCALE, default 1: clk cycles per PWM counter tick (>=1).
REQ-004 SHALL have parameter DEAD_TIME, default 16: clk cycles of forced-off time on direction reversal (>=1).
REQ-005 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port speed  in  CHANNELS*WIDTH  duty per channel; channel i at bits [i*WIDTH +: WIDTH].
REQ-008 SHALL have port direction_control  in  CHANNELS  requested direction per channel.
REQ-009 SHALL have port motor_enable  out  CHANNELS  registered bridge enable (PWM) per channel.
REQ-010 SHALL have port motor_direction  out  CHANNELS  registered bridge direction per channel.
REQ-011 SHALL have port busy  out  CHANNELS  high while the channel is in dead time.
REQ-012 SHALL have port period_start  out  1  one-cycle pulse at each PWM period boundary.

Function
REQ-013 SHALL have a prescaler counting 0..PRESCALE-1 and asserting internal tick in the cycle it equals PRESCALE-1; with PRESCALE=1, tick is constant high.
REQ-014 SHALL have one WIDTH-bit PWM counter shared by all channels, free-running: +1 on each tick, wraps all-ones -> 0; period = 2^WIDTH ticks.
REQ-015 SHALL load each channel's shadow duty from speed on the edge where tick=1 and counter=all-ones (the same edge the counter wraps to 0); speed changes mid-period take no effect before the next boundary.
REQ-016 SHALL register period_start high for exactly the one cycle following the wrap edge (counter=0 after a wrap).
REQ-017 SHALL compute raw PWM per channel as (shadow = all-ones) OR (counter < shadow): shadow 0 -> never high; all-ones -> constantly high; else high for shadow ticks per period.
REQ-018 SHALL implement a per-channel FSM with states RUN and DEAD.
REQ-019 In RUN with direction_control[i] = motor_direction[i], SHALL register motor_enable[i] <= raw PWM (1 cycle latency from counter).
REQ-020 In RUN with direction_control[i] != motor_direction[i], SHALL on that edge enter DEAD, drive motor_enable[i] <= 0, load dead counter with DEAD_TIME-1.
REQ-021 In DEAD, SHALL hold motor_enable[i]=0, motor_direction[i] unchanged; decrement dead counter each clk cycle (not tick).
REQ-022 In DEAD with dead counter 0, SHALL on that edge set motor_direction[i] <= current direction_control[i], keep motor_enable[i]=0, return to RUN; PWM resumes the following edge.
REQ-023 If direction_control[i] reverts during DEAD, SHALL complete full dead time anyway; no early exit, no restart.
REQ-024 SHALL ensure motor_direction[i] never changes while motor_enable[i] is 1 and motor_enable[i]=0 for at least DEAD_TIME+1 consecutive cycles around any direction change.
REQ-025 SHALL drive busy[i] high exactly while channel i is in DEAD.
REQ-026 Channels SHALL be independent: a reversal on one channel does not disturb the others or the shared counter.

Reset
REQ-027 While rst=0, SHALL asynchronously force prescaler, counter, shadows, dead counters to 0, all FSMs to RUN, and motor_enable, motor_direction, busy, period_start to 0.
REQ-028 Reset asserted mid-DEAD SHALL abort the dead time; after release with direction_control=1 the channel SHALL perform a full DEAD sequence before enabling.
REQ-029 After release, first period_start SHALL occur 2^WIDTH*PRESCALE cycles later; shadows SHALL stay 0 (outputs off) until the first boundary.

Verification (CHANNELS=2, WIDTH=4, PRESCALE=1, DEAD_TIME=3 unless noted)
REQ-030 speed ch0=4'h4 held, direction 0 -> after first boundary, motor_enable[0] high 4 of every 16 cycles, period_start every 16 cycles.
REQ-031 ch0=4'h0, ch1=4'hF -> motor_enable[0] constantly 0, motor_enable[1] constantly 1 after first boundary.
REQ-032 ch0 speed 4->8 at counter=5 -> current period keeps 4-cycle pulse; next period 8-cycle pulse.
REQ-033 ch1 at full speed, toggle direction_control[1] -> motor_enable[1] 0 next edge, busy[1] high 3 cycles, motor_direction[1] flips at the 3rd edge, enable back 1 edge later; ch0 undisturbed.
REQ-034 rst low mid-DEAD -> all outputs 0 immediately without a clock edge; after release with direction_control=1, busy high 3 cycles before any enable.
REQ-035 PRESCALE=3, speed=4'h2 -> period_start every 48 cycles, motor_enable high 6 consecutive cycles per period.
